// File: rtl/tns_enc_03_seq.sv
// Sequential greedy encoder: binary word -> 3-bit TNS codeword {A,B,C}, one weight per cycle.
// Optional TNS_ENC_STAT_EN adds a saturating err_cnt output counting errored output handshakes.
module tns_enc_03_seq #(
  parameter int unsigned BLEN = 4,
  parameter int unsigned W_A  = 3,
  parameter int unsigned W_B  = 2,
  parameter int unsigned W_C  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BLEN-1:0] datain,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      codeout,
  output logic            err
`ifdef TNS_ENC_STAT_EN
  ,
  output logic [15:0]     err_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, S_A, S_B, S_C, OUT} state_t;

  localparam logic [BLEN-1:0] WA = BLEN'(W_A);
  localparam logic [BLEN-1:0] WB = BLEN'(W_B);
  localparam logic [BLEN-1:0] WC = BLEN'(W_C);

  state_t          state_q, state_d;
  logic [BLEN-1:0] rem_q, rem_d;
  logic [1:0]      bits_q, bits_d;   // working A/B bits; C goes straight to codeout
  logic [2:0]      codeout_q, codeout_d;
  logic            err_q, err_d;
  logic            out_valid_q, out_valid_d;

  logic [BLEN-1:0] w_sel;
  logic [BLEN-1:0] rem_sub;
  logic            ge;

  always_comb begin
    w_sel = '0;
    case (state_q)
      S_A:     w_sel = WA;
      S_B:     w_sel = WB;
      S_C:     w_sel = WC;
      default: w_sel = '0;
    endcase
    ge      = (rem_q >= w_sel);
    rem_sub = rem_q - w_sel;
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    bits_d      = bits_q;
    codeout_d   = codeout_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rem_d   = datain;
          bits_d  = '0;
          state_d = S_A;
        end
      end
      S_A: begin
        bits_d[1] = ge;
        if (ge) rem_d = rem_sub;
        state_d = S_B;
      end
      S_B: begin
        bits_d[0] = ge;
        if (ge) rem_d = rem_sub;
        state_d = S_C;
      end
      S_C: begin
        // Outputs are only published here, so they stay stable through OUT.
        codeout_d   = {bits_q, ge};
        err_d       = ((ge ? rem_sub : rem_q) != '0);
        rem_d       = ge ? rem_sub : rem_q;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      bits_q      <= '0;
      codeout_q   <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      bits_q      <= bits_d;
      codeout_q   <= codeout_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign codeout   = codeout_q;
  assign err       = err_q;

`ifdef TNS_ENC_STAT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == OUT) && out_ready && err_q && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_tns_enc_03_seq.sv
// Self-checking bench for tns_enc_03_seq (W_A=3, W_B=2, W_C=1, BLEN=4) with a greedy reference model.
module tb_tns_enc_03_seq;

  localparam int BLEN = 4;
  localparam int WA = 3, WB = 2, WC = 1;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [BLEN-1:0] datain;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      codeout;
  logic            err;
`ifdef TNS_ENC_STAT_EN
  logic [15:0]     err_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  tns_enc_03_seq #(.BLEN(BLEN), .W_A(WA), .W_B(WB), .W_C(WC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .datain(datain),
    .out_valid(out_valid), .out_ready(out_ready), .codeout(codeout), .err(err)
`ifdef TNS_ENC_STAT_EN
    , .err_cnt(err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Greedy reference: {code[2:0], err}
  function automatic logic [3:0] model(input int v);
    int w[3];
    int r;
    logic [2:0] c;
    w[0] = WA; w[1] = WB; w[2] = WC;
    r = v;
    c = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (r >= w[i]) begin
        c[2-i] = 1'b1;
        r -= w[i];
      end
    end
    return {c, (r != 0)};
  endfunction

  function automatic int decode(input logic [2:0] c);
    return int'(c[2]) * WA + int'(c[1]) * WB + int'(c[0]) * WC;
  endfunction

  task automatic check_cnt(input string tag);
`ifdef TNS_ENC_STAT_EN
    chk(tag, {16'h0, err_cnt}, exp_cnt);
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  // Send one word, hold out_ready low for 'stall' cycles of OUT, then complete the handshake.
  task automatic encode(input int v, input int stall);
    logic [3:0] m;
    logic [2:0] held;
    int n;
    m = model(v);
    datain    = BLEN'(v);
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    chk($sformatf("in_ready_idle_%0d", v), in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk($sformatf("latency_%0d", v), n, 4);
    chk($sformatf("code_%0d", v), codeout, m[3:1]);
    chk($sformatf("err_%0d", v), err, m[0]);
    chk($sformatf("in_ready_busy_%0d", v), in_ready, 1'b0);
    if (!m[0]) chk($sformatf("roundtrip_%0d", v), decode(codeout), v);
    held = codeout;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      datain   = BLEN'(v + 1);
      tick();
      chk($sformatf("stall_valid_%0d", v), out_valid, 1'b1);
      chk($sformatf("stall_code_%0d", v), codeout, held);
      chk($sformatf("stall_ready_%0d", v), in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    if (m[0] && exp_cnt < 16'hFFFF) exp_cnt++;
    chk($sformatf("pulse_%0d", v), out_valid, 1'b0);
    chk($sformatf("back_idle_%0d", v), in_ready, 1'b1);
    check_cnt($sformatf("err_cnt_%0d", v));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; datain = '0; out_ready = 1'b0;
    tick();
    chk("rst_in_ready", in_ready, 1'b0);
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_codeout", codeout, 3'b000);
    chk("rst_err", err, 1'b0);
    check_cnt("rst_err_cnt");
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);

    // Reset while in S_B abandons the word
    datain = 4'd5; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready_rst", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        tick();
        seen |= out_valid;
      end
      chk("midrst_no_output", seen, 1'b0);
    end
    check_cnt("midrst_err_cnt");

    // rst and in_valid together: nothing captured
    rst = 1'b1; in_valid = 1'b1; datain = 4'd6;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rstwin_in_ready", in_ready, 1'b1);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        tick();
        seen |= out_valid;
      end
      chk("rstwin_no_output", seen, 1'b0);
    end

    encode(4, 0);
    for (int v = 0; v <= 6; v++) encode(v, 0);
    encode(9, 0);
    encode(5, 10);
    encode(15, 2);

    for (int i = 0; i < 30; i++) encode(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
